systolic_weight_feeder: RTL

SYSTOLIC_WEIGHT_FEEDER -- requirements
Module: systolic_weight_feeder

---
 rtl/systolic_weight_feeder_pkg.sv | 16 +
 rtl/systolic_weight_feeder.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/systolic_weight_feeder_pkg.sv
// rtl/systolic_weight_feeder_pkg.sv - shared hyper-parameters for the systolic weight feeder
//
// Purpose : array dimensions and the signed weight width shared with the rest
//           of the accelerator.
// Ports   : none (package only).
`ifndef SYSTOLIC_WEIGHT_WIDTH
`define SYSTOLIC_WEIGHT_WIDTH 8
`endif

package systolic_weight_feeder_pkg;

  localparam int SWF_ARRAY_ROWS   = 16;
  localparam int SWF_ARRAY_COLS   = 16;
  localparam int SWF_WEIGHT_WIDTH = `SYSTOLIC_WEIGHT_WIDTH;

endpackage

// File: rtl/systolic_weight_feeder.sv
// rtl/systolic_weight_feeder.sv - double-buffered weight tile loader for a systolic array
//
// Purpose : accepts weight tiles one row beat at a time, writes them into one
//           of two PE weight banks (ping-pong) and hands complete tiles to the
//           array controller in load order.
// Ports   : s_clk, s_rst_n           - clock, async active-low reset
//           w_in_valid/ready/data    - row beat input handshake (COLS*WW bits)
//           weight_valid [ROWS]      - one-hot row write strobe
//           weights [COLS*WW]        - registered row data, broadcast to all rows
//           weight_LoadPtr           - bank being written
//           weight_CalcPtr           - bank used for multiply
//           calc_ready               - bank at CalcPtr holds a full tile, FSM idle
//           calc_start, calc_done    - single-cycle pulses from the array controller
//           calc_busy                - a tile is in use
`ifndef SYSTOLIC_WEIGHT_WIDTH
`define SYSTOLIC_WEIGHT_WIDTH 8
`endif

module systolic_weight_feeder
  import systolic_weight_feeder_pkg::*;
#(
  parameter int ROWS = SWF_ARRAY_ROWS,
  parameter int COLS = SWF_ARRAY_COLS,
  parameter int WW   = `SYSTOLIC_WEIGHT_WIDTH
) (
  input  logic               s_clk,
  input  logic               s_rst_n,
  input  logic               w_in_valid,
  output logic               w_in_ready,
  input  logic [COLS*WW-1:0] w_in_data,
  output logic [ROWS-1:0]    weight_valid,
  output logic [COLS*WW-1:0] weights,
  output logic               weight_LoadPtr,
  output logic               weight_CalcPtr,
  output logic               calc_ready,
  input  logic               calc_start,
  input  logic               calc_done,
  output logic               calc_busy
);

  localparam int RCW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [RCW-1:0] LAST_ROW = RCW'(ROWS - 1);

  typedef enum logic {
    C_IDLE = 1'b0,
    C_BUSY = 1'b1
  } calc_state_e;

  calc_state_e          state_q, state_d;
  logic [1:0]           bank_full_q, bank_full_d;
  logic                 lp_q, lp_d;
  logic                 cp_q, cp_d;
  logic [RCW-1:0]       row_cnt_q, row_cnt_d;
  logic                 fill_pending_q, fill_pending_d;
  logic [ROWS-1:0]      weight_valid_q, weight_valid_d;
  logic [COLS*WW-1:0]   weights_q, weights_d;
  logic                 load_ptr_q, load_ptr_d;
  logic                 accept;

  // A bank that is still full is either waiting for, or in use by, the
  // calc side; the commit gap keeps a new tile from starting before the
  // previous one is marked full and LP has moved on.
  assign w_in_ready     = ~bank_full_q[lp_q] & ~fill_pending_q;
  assign accept         = w_in_valid & w_in_ready;
  assign calc_ready     = bank_full_q[cp_q] & (state_q == C_IDLE);
  assign calc_busy      = (state_q == C_BUSY);
  assign weight_valid   = weight_valid_q;
  assign weights        = weights_q;
  assign weight_LoadPtr = load_ptr_q;
  assign weight_CalcPtr = cp_q;

  always_comb begin
    state_d        = state_q;
    bank_full_d    = bank_full_q;
    lp_d           = lp_q;
    cp_d           = cp_q;
    row_cnt_d      = row_cnt_q;
    fill_pending_d = fill_pending_q;
    weight_valid_d = '0;
    weights_d      = weights_q;
    load_ptr_d     = load_ptr_q;

    if (accept) begin
      weight_valid_d = ROWS'(1) << row_cnt_q;
      weights_d      = w_in_data;
      load_ptr_d     = lp_q;
      if (row_cnt_q == LAST_ROW) begin
        fill_pending_d = 1'b1;
      end else begin
        row_cnt_d = row_cnt_q + 1'b1;
      end
    end

    // Commit one cycle after the final row strobe so calc_ready never
    // overlaps the last weight write.
    if (fill_pending_q) begin
      fill_pending_d     = 1'b0;
      bank_full_d[lp_q]  = 1'b1;
      lp_d               = ~lp_q;
      row_cnt_d          = '0;
    end

    // A commit and a release on the same edge always target different
    // banks (LP == CP with CP busy would mean loading into a full bank),
    // so both edits to bank_full_d survive.
    unique case (state_q)
      C_IDLE: begin
        if (calc_start && calc_ready) begin
          state_d = C_BUSY;
        end
      end
      C_BUSY: begin
        if (calc_done) begin
          state_d           = C_IDLE;
          bank_full_d[cp_q] = 1'b0;
          cp_d              = ~cp_q;
        end
      end
      default: state_d = C_IDLE;
    endcase
  end

  always_ff @(posedge s_clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state_q        <= C_IDLE;
      bank_full_q    <= '0;
      lp_q           <= 1'b0;
      cp_q           <= 1'b0;
      row_cnt_q      <= '0;
      fill_pending_q <= 1'b0;
      weight_valid_q <= '0;
      weights_q      <= '0;
      load_ptr_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      bank_full_q    <= bank_full_d;
      lp_q           <= lp_d;
      cp_q           <= cp_d;
      row_cnt_q      <= row_cnt_d;
      fill_pending_q <= fill_pending_d;
      weight_valid_q <= weight_valid_d;
      weights_q      <= weights_d;
      load_ptr_q     <= load_ptr_d;
    end
  end

endmodule
